// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   Parametrised register bank of DEPTH words x WIDTH bits. It has one
//   synchronous write port and two independent combinational read ports.
//   There is an optional same-cycle write-to-read bypass and an optional
//   hardwired-zero register 0.
//
// Parameters
//   WIDTH    : bits per register
//   DEPTH    : number of registers (2..256, need not be a power of two)
//   BYPASS   : 1 -> a read of the word being written returns wdata this cycle
//   ZERO_REG : 1 -> register 0 reads as zero and ignores writes
//   AW       : address width, clog2(DEPTH) (derived, not overridable)
//
// Ports
//   clk      in           rising-edge clock
//   rst      in           synchronous active-high reset, clears every word
//   we       in           write enable
//   waddr    in  [AW]     write address (out-of-range writes are dropped)
//   wdata    in  [WIDTH]  write data
//   raddr_a  in  [AW]     read address, port A
//   rdata_a  out [WIDTH]  read data, port A (combinational)
//   raddr_b  in  [AW]     read address, port B
//   rdata_b  out [WIDTH]  read data, port B (combinational)
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    // One extra bit so DEPTH itself is representable when DEPTH = 2**AW.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_hit_s;
    logic             byp_ok_s;

    // True when the address selects an implemented word.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_W);
    endfunction

    // True when the address selects the hardwired-zero word.
    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == {AW{1'b0}});
    endfunction

    // Write qualifier: enabled, implemented and not the hardwired-zero word.
    always_comb begin
        wr_hit_s = we && in_range(waddr) && !is_zero_reg(waddr);
        // Bypass is masked during reset because the write will be lost.
        byp_ok_s = (BYPASS != 0) && wr_hit_s && !rst;
    end

    // Next-state for each word: take wdata on an address match, else hold.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_hit_s && (waddr == i[AW-1:0])) begin
                mem_d[i] = wdata;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Storage update; reset takes priority over any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port A mux.
    always_comb begin
        rdata_a = {WIDTH{1'b0}};
        if (!in_range(raddr_a)) begin
            rdata_a = {WIDTH{1'b0}};
        end else if (is_zero_reg(raddr_a)) begin
            rdata_a = {WIDTH{1'b0}};
        end else if (byp_ok_s && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = mem_q[raddr_a];
        end
    end

    // Read port B mux.
    always_comb begin
        rdata_b = {WIDTH{1'b0}};
        if (!in_range(raddr_b)) begin
            rdata_b = {WIDTH{1'b0}};
        end else if (is_zero_reg(raddr_b)) begin
            rdata_b = {WIDTH{1'b0}};
        end else if (byp_ok_s && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = mem_q[raddr_b];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Drives four reg_file configurations from shared stimulus:
//     cfg0: DEPTH=4 BYPASS=1 ZERO_REG=0
//     cfg1: DEPTH=4 BYPASS=0 ZERO_REG=0
//     cfg2: DEPTH=4 BYPASS=1 ZERO_REG=1
//     cfg3: DEPTH=3 BYPASS=1 ZERO_REG=0
//   Each read port is compared before and after every edge against a simple
//   array model of the register bank.
// ---------------------------------------------------------------------------
module tb_reg_file;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [1:0] raddr_a;
    logic [1:0] raddr_b;
    logic [7:0] ra [4];
    logic [7:0] rb [4];

    int tests = 0;
    int fails = 0;

    // Reference model: per-configuration word contents and traits.
    int model_mem [4][4];
    int cfg_depth [4] = '{4, 4, 4, 3};
    int cfg_byp   [4] = '{1, 0, 1, 1};
    int cfg_zr    [4] = '{0, 0, 1, 0};

    always #5 clk = ~clk;

    reg_file #(.WIDTH(8), .DEPTH(4), .BYPASS(1), .ZERO_REG(0)) u_cfg0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(ra[0]), .raddr_b(raddr_b), .rdata_b(rb[0]));
    reg_file #(.WIDTH(8), .DEPTH(4), .BYPASS(0), .ZERO_REG(0)) u_cfg1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(ra[1]), .raddr_b(raddr_b), .rdata_b(rb[1]));
    reg_file #(.WIDTH(8), .DEPTH(4), .BYPASS(1), .ZERO_REG(1)) u_cfg2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(ra[2]), .raddr_b(raddr_b), .rdata_b(rb[2]));
    reg_file #(.WIDTH(8), .DEPTH(3), .BYPASS(1), .ZERO_REG(0)) u_cfg3 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(ra[3]), .raddr_b(raddr_b), .rdata_b(rb[3]));

    function automatic bit writable(int c, int a);
        return (a < cfg_depth[c]) && !(cfg_zr[c] != 0 && a == 0);
    endfunction

    // Expected read value from the architectural rules.
    function automatic logic [7:0] exp_read(int c, int a);
        if (a >= cfg_depth[c]) return 8'h00;
        if (cfg_zr[c] != 0 && a == 0) return 8'h00;
        if (cfg_byp[c] != 0 && we && !rst && a == int'(waddr) && writable(c, int'(waddr)))
            return wdata;
        return 8'(model_mem[c][a]);
    endfunction

    // Apply the effect of one rising edge to the model.
    task automatic model_edge();
        for (int c = 0; c < 4; c++) begin
            if (rst) begin
                for (int a = 0; a < 4; a++) model_mem[c][a] = 0;
            end else if (we && writable(c, int'(waddr))) begin
                model_mem[c][int'(waddr)] = int'(wdata);
            end
        end
    endtask

    task automatic check_all(string tag);
        logic [7:0] e;
        for (int c = 0; c < 4; c++) begin
            e = exp_read(c, int'(raddr_a));
            tests++;
            assert (ra[c] === e) else begin
                fails++;
                $error("FAIL %s cfg%0d port A addr %0d: got %h expected %h",
                       tag, c, raddr_a, ra[c], e);
            end
            e = exp_read(c, int'(raddr_b));
            tests++;
            assert (rb[c] === e) else begin
                fails++;
                $error("FAIL %s cfg%0d port B addr %0d: got %h expected %h",
                       tag, c, raddr_b, rb[c], e);
            end
        end
    endtask

    // Check before the edge, clock once, then check after it.
    task automatic step(string tag);
        #1;
        check_all({tag, "_pre"});
        @(posedge clk);
        model_edge();
        #1;
        check_all({tag, "_post"});
    endtask

    task automatic drive(logic r, logic w, logic [1:0] wa, logic [7:0] wd,
                         logic [1:0] a, logic [1:0] b);
        rst = r; we = w; waddr = wa; wdata = wd; raddr_a = a; raddr_b = b;
    endtask

    initial begin
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 4; a++) model_mem[c][a] = 0;

        // First reset: contents are unknown until this edge, so no pre-check.
        drive(1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0;

        // Read-all sweep after reset.
        for (int a = 0; a < 4; a++) begin
            raddr_a = 2'(a);
            raddr_b = 2'(3 - a);
            #1;
            check_all("reset_sweep");
        end

        // Write 0x11..0x44 to addresses 0..3.
        drive(1'b0, 1'b1, 2'd0, 8'h11, 2'd2, 2'd3); step("wr0");
        drive(1'b0, 1'b1, 2'd1, 8'h22, 2'd2, 2'd3); step("wr1");
        drive(1'b0, 1'b1, 2'd2, 8'h33, 2'd2, 2'd3); step("wr2");
        drive(1'b0, 1'b1, 2'd3, 8'h44, 2'd2, 2'd3); step("wr3");

        // Hold with we=0 for four cycles.
        drive(1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 2'd3);
        for (int i = 0; i < 4; i++) step("hold");

        // Same-cycle bypass to address 1.
        drive(1'b0, 1'b1, 2'd1, 8'hA5, 2'd1, 2'd1); step("bypass");

        // Reset priority over a write, then the same write without reset.
        drive(1'b1, 1'b1, 2'd0, 8'hFF, 2'd0, 2'd1); step("rst_prio");
        drive(1'b0, 1'b1, 2'd0, 8'hFF, 2'd0, 2'd1); step("after_rst");

        // Zero-register writes, then write to address 3.
        drive(1'b0, 1'b1, 2'd0, 8'h7E, 2'd0, 2'd0); step("zero_reg");
        drive(1'b0, 1'b1, 2'd3, 8'h7E, 2'd3, 2'd0); step("wr_addr3");

        // Out-of-range write for DEPTH=3, then sweep.
        drive(1'b0, 1'b1, 2'd3, 8'h5C, 2'd3, 2'd2); step("oor_write");
        we = 1'b0;
        for (int a = 0; a < 4; a++) begin
            raddr_a = 2'(a);
            raddr_b = 2'(3 - a);
            #1;
            check_all("oor_sweep");
        end

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 8'($urandom),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
